// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver/transmitter FSM encoding, register word
// offsets, STATUS bit positions and the STATUS word packer.
package uart_pkg;

    typedef enum logic [2:0] {
        RX_IDLE   = 3'd0,
        RX_START  = 3'd1,
        RX_DATA   = 3'd2,
        RX_PARITY = 3'd3,
        RX_STOP   = 3'd4
    } rx_state_t;

    typedef enum logic [1:0] {
        BUS_IDLE = 2'd0,
        BUS_ACK  = 2'd1,
        BUS_DONE = 2'd2
    } bus_state_t;

    typedef struct packed {
        rx_state_t  rx;
        bus_state_t bus;
    } dbg_state_t;

    localparam logic [29:0] OFF_DATA   = 30'd0;
    localparam logic [29:0] OFF_STATUS = 30'd1;

    localparam int STAT_NE        = 0;
    localparam int STAT_OVR       = 1;
    localparam int STAT_FERR      = 2;
    localparam int STAT_PERR      = 3;
    localparam int STAT_COUNT_LSB = 24;

    function automatic logic [31:0] status_word(input logic [7:0] cnt,
                                                input logic       perr,
                                                input logic       ferr,
                                                input logic       ovr,
                                                input logic       not_empty);
        logic [31:0] w;
        w                                    = '0;
        w[STAT_COUNT_LSB +: 8]               = cnt;
        w[STAT_PERR]                         = perr;
        w[STAT_FERR]                         = ferr;
        w[STAT_OVR]                          = ovr;
        w[STAT_NE]                           = not_empty;
        return w;
    endfunction

endpackage

// File: rtl/rx_fifo.sv
// Byte FIFO for the UART receiver; a push into a full FIFO is accepted only
// when a pop happens in the same cycle.
module rx_fifo #(
    parameter int DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     clr,
    input  logic                     push,
    input  logic                     pop,
    input  logic [7:0]               din,
    output logic [7:0]               dout,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);

    logic [7:0]    mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic          do_push;
    logic          do_pop;

    assign empty   = (count == '0);
    assign full    = (count == (AW+1)'(DEPTH));
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign dout    = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= din;
        end
    end

    // Pointers are exactly AW bits wide, so they wrap modulo DEPTH for free.
    always_ff @(posedge clk) begin
        if (clr) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/uart_rx_slave.sv
// Memory-mapped UART receiver: 16x oversampling RX FSM feeding rx_fifo, read via DATA/STATUS.
// Define UART_RX_PARITY_EN to expect an even-parity bit after the eight data bits.
module uart_rx_slave
    import uart_pkg::*;
#(
    parameter int          CLK_HZ     = 50_000_000,
    parameter int          BAUD       = 115200,
    parameter logic [29:0] BASE_WADDR = 30'h0000_4000,
    parameter int          FIFO_DEPTH = 8
) (
    input  logic        clk,
    input  logic        clr,
    input  logic [31:0] BUS_addr,
    inout  tri   [31:0] BUS_data,
    input  logic        BUS_req,
    inout  tri          BUS_ready,
    input  logic        BUS_RW,
    input  logic        RxD,
    output logic        RxD_valid,
    output dbg_state_t  dbg_state
);

    localparam int            DIV_RAW  = CLK_HZ / (16 * BAUD);
    localparam int            DIV      = (DIV_RAW < 1) ? 1 : DIV_RAW;
    localparam int            CW       = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int            AW       = $clog2(FIFO_DEPTH);
    localparam logic [CW-1:0] DIV_LAST = CW'(DIV - 1);

    rx_state_t   rx_state, rx_nxt;
    bus_state_t  bus_state, bus_nxt;

    logic          rxd_m, rxd_s, rxd_d;
    logic          fall;
    logic [CW-1:0] baud_cnt;
    logic          tick;
    logic [3:0]    tick_cnt;
    logic          start_mid;
    logic          bit_mid;
    logic [2:0]    bit_idx;
    logic [7:0]    shreg;
    logic          brk_wait;
    logic          par_bad;
    logic          push_req;
    logic          set_ferr;
    logic          set_perr;
    logic          ovr_q, ferr_q, perr_q;

    logic          fifo_pop;
    logic [7:0]    fifo_dout;
    logic          fifo_full;
    logic          fifo_empty;
    logic [AW:0]   fifo_count;

    logic          sel;
    logic          is_status;
    logic          accept;
    logic          wr_status;
    logic          rd_q;
    logic          pop_pend;
    logic [31:0]   rdata_q;
    logic          unused_bits;

    // Synchronizer and edge history all reset low: a line that is already low
    // at reset must first return high before a new start bit can be seen.
    always_ff @(posedge clk) begin
        if (clr) begin
            rxd_m <= 1'b0;
            rxd_s <= 1'b0;
            rxd_d <= 1'b0;
        end else begin
            rxd_m <= RxD;
            rxd_s <= rxd_m;
            rxd_d <= rxd_s;
        end
    end

    assign fall      = rxd_d && !rxd_s;
    assign tick      = (baud_cnt == DIV_LAST);
    assign start_mid = tick && (rx_state == RX_START) && (tick_cnt == 4'd7);
    assign bit_mid   = tick && (tick_cnt == 4'd15);

    always_ff @(posedge clk) begin
        if (clr) begin
            rx_state <= RX_IDLE;
        end else begin
            rx_state <= rx_nxt;
        end
    end

    always_comb begin
        rx_nxt   = rx_state;
        push_req = 1'b0;
        set_ferr = 1'b0;
        set_perr = 1'b0;
        case (rx_state)
            RX_IDLE: begin
                if (fall) rx_nxt = RX_START;
            end
            RX_START: begin
                if (start_mid) rx_nxt = rxd_s ? RX_IDLE : RX_DATA;
            end
            RX_DATA: begin
                if (bit_mid && bit_idx == 3'd7) begin
`ifdef UART_RX_PARITY_EN
                    rx_nxt = RX_PARITY;
`else
                    rx_nxt = RX_STOP;
`endif
                end
            end
`ifdef UART_RX_PARITY_EN
            RX_PARITY: begin
                if (bit_mid) begin
                    rx_nxt   = RX_STOP;
                    set_perr = ^{shreg, rxd_s};
                end
            end
`endif
            RX_STOP: begin
                if (brk_wait) begin
                    if (rxd_s) rx_nxt = RX_IDLE;
                end else if (bit_mid) begin
                    if (rxd_s) begin
                        rx_nxt   = RX_IDLE;
                        push_req = !par_bad;
                    end else begin
                        set_ferr = 1'b1;
                    end
                end
            end
            default: rx_nxt = RX_IDLE;
        endcase
    end

    // Baud and tick counters restart on every start edge so sampling is
    // phase-aligned to the frame rather than to a free-running divider.
    always_ff @(posedge clk) begin
        if (clr) begin
            baud_cnt <= '0;
            tick_cnt <= '0;
            bit_idx  <= '0;
            shreg    <= '0;
            brk_wait <= 1'b0;
        end else begin
            if (rx_state == RX_IDLE || tick) begin
                baud_cnt <= '0;
            end else begin
                baud_cnt <= baud_cnt + 1'b1;
            end

            if (rx_state == RX_IDLE || start_mid) begin
                tick_cnt <= '0;
            end else if (tick) begin
                tick_cnt <= tick_cnt + 1'b1;
            end

            if (rx_state == RX_IDLE) begin
                bit_idx <= '0;
            end else if (rx_state == RX_DATA && bit_mid) begin
                bit_idx <= bit_idx + 1'b1;
                shreg   <= {rxd_s, shreg[7:1]};
            end

            if (rx_state == RX_IDLE) begin
                brk_wait <= 1'b0;
            end else if (set_ferr) begin
                brk_wait <= 1'b1;
            end
        end
    end

`ifdef UART_RX_PARITY_EN
    always_ff @(posedge clk) begin
        if (clr || rx_state == RX_IDLE) begin
            par_bad <= 1'b0;
        end else if (set_perr) begin
            par_bad <= 1'b1;
        end
    end
`else
    assign par_bad = 1'b0;
`endif

    rx_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .clr   (clr),
        .push  (push_req),
        .pop   (fifo_pop),
        .din   (shreg),
        .dout  (fifo_dout),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count)
    );

    assign RxD_valid = !fifo_empty;

    // Bus handshake: a transaction is accepted in the cycle BUS_req is high with
    // a matching address; BUS_ready then reads 1 on every following cycle until
    // BUS_req drops, reads 0 for one cycle, and is released. Read data is
    // captured at acceptance and is valid whenever BUS_ready is 1.
    assign sel       = BUS_req && (BUS_addr[29:0] == BASE_WADDR + OFF_DATA ||
                                   BUS_addr[29:0] == BASE_WADDR + OFF_STATUS);
    assign is_status = (BUS_addr[29:0] == BASE_WADDR + OFF_STATUS);
    assign accept    = (bus_state == BUS_IDLE) && sel;
    assign wr_status = accept && !BUS_RW && is_status;
    assign fifo_pop  = (bus_state == BUS_ACK) && pop_pend;

    always_ff @(posedge clk) begin
        if (clr) begin
            bus_state <= BUS_IDLE;
        end else begin
            bus_state <= bus_nxt;
        end
    end

    always_comb begin
        bus_nxt = bus_state;
        case (bus_state)
            BUS_IDLE: if (sel) bus_nxt = BUS_ACK;
            BUS_ACK:  if (!BUS_req) bus_nxt = BUS_DONE;
            BUS_DONE: bus_nxt = BUS_IDLE;
            default:  bus_nxt = BUS_IDLE;
        endcase
    end

    // Only the bus pops, so the head captured at acceptance is still the head
    // when the pop lands on the first ready cycle.
    always_ff @(posedge clk) begin
        if (clr) begin
            rd_q     <= 1'b0;
            pop_pend <= 1'b0;
            rdata_q  <= '0;
        end else if (accept) begin
            rd_q     <= BUS_RW;
            pop_pend <= BUS_RW && !is_status && !fifo_empty;
            rdata_q  <= is_status
                        ? status_word(8'(fifo_count), perr_q, ferr_q, ovr_q, !fifo_empty)
                        : {24'b0, fifo_empty ? 8'h00 : fifo_dout};
        end else if (bus_state == BUS_ACK) begin
            pop_pend <= 1'b0;
        end
    end

    // Clears come first so an error arriving in the same cycle still wins.
    always_ff @(posedge clk) begin
        if (clr) begin
            ovr_q  <= 1'b0;
            ferr_q <= 1'b0;
            perr_q <= 1'b0;
        end else begin
            if (wr_status && BUS_data[STAT_OVR])  ovr_q  <= 1'b0;
            if (wr_status && BUS_data[STAT_FERR]) ferr_q <= 1'b0;
            if (wr_status && BUS_data[STAT_PERR]) perr_q <= 1'b0;
            if (push_req && fifo_full && !fifo_pop) ovr_q <= 1'b1;
            if (set_ferr) ferr_q <= 1'b1;
            if (set_perr) perr_q <= 1'b1;
        end
    end

    assign BUS_ready = (bus_state == BUS_ACK)  ? 1'b1 :
                       (bus_state == BUS_DONE) ? 1'b0 : 1'bz;
    assign BUS_data  = (bus_state == BUS_ACK && rd_q) ? rdata_q : {32{1'bz}};

    assign dbg_state.rx  = rx_state;
    assign dbg_state.bus = bus_state;

    assign unused_bits = ^{BUS_addr[31:30], BUS_data[31:4], BUS_data[STAT_NE]};

endmodule
